tile_ram_arbiter: RTL and testbench

Shares the single-port tile RAM (300 tiles, 7-bit tile type per entry) between two requesters: the display-side tile fetch and the game-logic port that reads and updates board tiles. Display fetches have priority. A wait counter guarantees the game port a slot within a bounded number of cycles. The block sits between the tile fetch / game FSM and the tile RAM, issues registered RAM commands, and returns read data to the requester that owns each access.

---
 rtl/tile_ram_arbiter.sv | 237 +++++++++++++++++++++++
 tb/tb_tile_ram_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_ram_arbiter.sv
// tile_ram_arbiter: shares the single-port tile RAM between display fetch
// (priority) and the game-logic port (bounded wait via force-grant).
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   disp_req_i/addr_i            display request, held until disp_ack_o
//   disp_ack_o                   combinational display grant
//   disp_valid_o/data_o          display read return, 3 cycles after ack
//   game_req_i/we_i/addr_i/      game request (read or write), held until
//   game_wdata_i                 game_ack_o
//   game_ack_o                   combinational game grant
//   game_valid_o/rdata_o         game read return, 3 cycles after ack
//   game_err_o                   out-of-range game access flag
//   ram_en_o/we_o/addr_o/wdata_o registered RAM command (cycle after ack)
//   ram_rdata_i                  RAM read data, one cycle after command
//
// Build option: define TILE_ARB_BOUNDS_CHECK_EN to reject game accesses at
// or above TILE_COUNT (acked, no RAM command, game_err_o pulse). Without it
// game_err_o stays 0 and every address goes to the RAM.

module tile_ram_arbiter #(
   parameter int RAM_DATA_WIDTH = 7,
   parameter int RAM_ADDR_WIDTH = 9,
   parameter int TILE_COUNT     = 300,
   parameter int GAME_WAIT_MAX  = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      disp_req_i,
   input  logic [RAM_ADDR_WIDTH-1:0] disp_addr_i,
   output logic                      disp_ack_o,
   output logic                      disp_valid_o,
   output logic [RAM_DATA_WIDTH-1:0] disp_data_o,
   input  logic                      game_req_i,
   input  logic                      game_we_i,
   input  logic [RAM_ADDR_WIDTH-1:0] game_addr_i,
   input  logic [RAM_DATA_WIDTH-1:0] game_wdata_i,
   output logic                      game_ack_o,
   output logic                      game_valid_o,
   output logic [RAM_DATA_WIDTH-1:0] game_rdata_o,
   output logic                      game_err_o,
   output logic                      ram_en_o,
   output logic                      ram_we_o,
   output logic [RAM_ADDR_WIDTH-1:0] ram_addr_o,
   output logic [RAM_DATA_WIDTH-1:0] ram_wdata_o,
   input  logic [RAM_DATA_WIDTH-1:0] ram_rdata_i
);

   typedef enum logic {
      S_DISP_PRIO  = 1'b0,
      S_GAME_FORCE = 1'b1
   } arb_state_e;

   // Return owner of an access; game writes travel as TAG_NONE.
   typedef enum logic [1:0] {
      TAG_NONE  = 2'b00,
      TAG_DISP  = 2'b01,
      TAG_GREAD = 2'b10
   } tag_e;

   localparam logic [3:0] WAIT_MAX = 4'(GAME_WAIT_MAX);
   localparam logic [RAM_ADDR_WIDTH-1:0] TILE_LIMIT =
      RAM_ADDR_WIDTH'(TILE_COUNT);

   arb_state_e state_q, state_d;
   logic [3:0] cnt_q, cnt_d;

   logic game_oob_raw;
   logic game_oob;

   logic                      cmd_en_d;
   logic                      cmd_we_d;
   logic [RAM_ADDR_WIDTH-1:0] cmd_addr_d;
   logic [RAM_DATA_WIDTH-1:0] cmd_wdata_d;
   tag_e                      tag_d;
   logic                      err_d;

   tag_e tag1_q, tag2_q;
   logic err1_q, err2_q;

   // ------------------------------------------------------------
   // Address range check
   // ------------------------------------------------------------
   assign game_oob_raw = (game_addr_i >= TILE_LIMIT);

`ifdef TILE_ARB_BOUNDS_CHECK_EN
   assign game_oob = game_oob_raw;
`else
   logic unused_oob;
   assign unused_oob = game_oob_raw;
   assign game_oob   = 1'b0;
`endif

   // ------------------------------------------------------------
   // Arbitration FSM: state register
   // ------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_DISP_PRIO;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // ------------------------------------------------------------
   // Arbitration FSM: grants, wait counter, next state
   // ------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      cnt_d      = '0;
      disp_ack_o = 1'b0;
      game_ack_o = 1'b0;

      unique case (state_q)
         S_DISP_PRIO: begin
            disp_ack_o = disp_req_i;
            game_ack_o = game_req_i & ~disp_req_i;
         end
         S_GAME_FORCE: begin
            game_ack_o = game_req_i;
            disp_ack_o = disp_req_i & ~game_req_i;
         end
         default: ;
      endcase

      // Counts consecutive denied cycles of a pending game request.
      if (game_req_i && !game_ack_o) begin
         cnt_d = cnt_q + 4'd1;
      end

      // Force is entered on the edge where the count reaches the limit,
      // so the game is granted in the very next cycle.
      unique case (state_q)
         S_DISP_PRIO: begin
            if (cnt_d == WAIT_MAX) begin
               state_d = S_GAME_FORCE;
            end
         end
         S_GAME_FORCE: begin
            if (game_ack_o || !game_req_i) begin
               state_d = S_DISP_PRIO;
            end
         end
         default: ;
      endcase
   end

   // ------------------------------------------------------------
   // Command mux for the granted requester
   // ------------------------------------------------------------
   always_comb begin
      cmd_en_d    = 1'b0;
      cmd_we_d    = 1'b0;
      cmd_addr_d  = ram_addr_o;
      cmd_wdata_d = ram_wdata_o;
      tag_d       = TAG_NONE;
      err_d       = 1'b0;

      unique case (1'b1)
         disp_ack_o: begin
            cmd_en_d   = 1'b1;
            cmd_addr_d = disp_addr_i;
            tag_d      = TAG_DISP;
         end
         game_ack_o: begin
            // Rejected accesses still need a read return, but no RAM cycle.
            cmd_en_d    = ~game_oob;
            cmd_we_d    = game_we_i & ~game_oob;
            cmd_addr_d  = game_addr_i;
            cmd_wdata_d = game_wdata_i;
            tag_d       = game_we_i ? TAG_NONE : TAG_GREAD;
            err_d       = game_oob;
         end
         default: ;
      endcase
   end

   // ------------------------------------------------------------
   // RAM command register (cycle N+1)
   // ------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ram_en_o    <= 1'b0;
         ram_we_o    <= 1'b0;
         ram_addr_o  <= '0;
         ram_wdata_o <= '0;
      end else begin
         ram_en_o    <= cmd_en_d;
         ram_we_o    <= cmd_we_d;
         ram_addr_o  <= cmd_addr_d;
         ram_wdata_o <= cmd_wdata_d;
      end
   end

   // ------------------------------------------------------------
   // Owner tag pipeline (N+1, N+2)
   // ------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tag1_q <= TAG_NONE;
         tag2_q <= TAG_NONE;
         err1_q <= 1'b0;
         err2_q <= 1'b0;
      end else begin
         tag1_q <= tag_d;
         tag2_q <= tag1_q;
         err1_q <= err_d;
         err2_q <= err1_q;
      end
   end

   // ------------------------------------------------------------
   // Read return registers (N+3); data holds between pulses
   // ------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         disp_valid_o <= 1'b0;
         disp_data_o  <= '0;
         game_valid_o <= 1'b0;
         game_rdata_o <= '0;
         game_err_o   <= 1'b0;
      end else begin
         disp_valid_o <= (tag2_q == TAG_DISP);
         game_valid_o <= (tag2_q == TAG_GREAD);
         game_err_o   <= err2_q;
         if (tag2_q == TAG_DISP) begin
            disp_data_o <= ram_rdata_i;
         end
         if (tag2_q == TAG_GREAD) begin
            game_rdata_o <= err2_q ? '0 : ram_rdata_i;
         end
      end
   end

endmodule

// File: tb/tb_tile_ram_arbiter.sv
// tb_tile_ram_arbiter: directed and random stimulus for tile_ram_arbiter,
// checked against a grant/latency/shadow-memory reference model.

module tb_tile_ram_arbiter;

   localparam int DW   = 7;
   localparam int AW   = 9;
   localparam int TC   = 300;
   localparam int WMAX = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst = 1'b1;
   logic          disp_req = 1'b0;
   logic [AW-1:0] disp_addr = '0;
   logic          game_req = 1'b0;
   logic          game_we = 1'b0;
   logic [AW-1:0] game_addr = '0;
   logic [DW-1:0] game_wdata = '0;

   logic          disp_ack, disp_valid, game_ack, game_valid, game_err;
   logic [DW-1:0] disp_data, game_rdata;
   logic          ram_en, ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata = '0;

   tile_ram_arbiter #(
      .RAM_DATA_WIDTH(DW),
      .RAM_ADDR_WIDTH(AW),
      .TILE_COUNT    (TC),
      .GAME_WAIT_MAX (WMAX)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .disp_req_i  (disp_req),
      .disp_addr_i (disp_addr),
      .disp_ack_o  (disp_ack),
      .disp_valid_o(disp_valid),
      .disp_data_o (disp_data),
      .game_req_i  (game_req),
      .game_we_i   (game_we),
      .game_addr_i (game_addr),
      .game_wdata_i(game_wdata),
      .game_ack_o  (game_ack),
      .game_valid_o(game_valid),
      .game_rdata_o(game_rdata),
      .game_err_o  (game_err),
      .ram_en_o    (ram_en),
      .ram_we_o    (ram_we),
      .ram_addr_o  (ram_addr),
      .ram_wdata_o (ram_wdata),
      .ram_rdata_i (ram_rdata)
   );

   // Single-port RAM with one-cycle registered read.
   logic [DW-1:0] ram [512];
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) ram[ram_addr] <= ram_wdata;
         else        ram_rdata <= ram[ram_addr];
      end
   end

   // Reference model state.
   logic [DW-1:0] shadow [512];
   int            cyc = 0;
   int            waited = 0;
   int            errors = 0;
   int            checks = 0;
   bit            e_en [64];
   bit            e_we [64];
   logic [AW-1:0] e_addr [64];
   logic [DW-1:0] e_wd [64];
   bit            e_dv [64];
   bit            e_gv [64];
   bit            e_err [64];
   logic [DW-1:0] e_dd [64];
   logic [DW-1:0] e_gd [64];
   logic [DW-1:0] last_dd = '0;
   logic [DW-1:0] last_gd = '0;
   bit            x_dack = 1'b0;
   bit            x_gack = 1'b0;
   logic          o_dack, o_gack;

   function automatic bit oob(input logic [AW-1:0] a);
`ifdef TILE_ARB_BOUNDS_CHECK_EN
      return (int'(a) >= TC);
`else
      return 1'b0;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_slot(input int s);
      e_en[s]  = 1'b0;
      e_we[s]  = 1'b0;
      e_dv[s]  = 1'b0;
      e_gv[s]  = 1'b0;
      e_err[s] = 1'b0;
   endtask

   // One clock cycle: check grants and registered outputs at the falling
   // edge, then book what this cycle's grants must produce later.
   task automatic cycle();
      int s, s1, s3;
      @(negedge clk);
      s  = cyc % 64;
      s1 = (cyc + 1) % 64;
      s3 = (cyc + 3) % 64;
      x_gack = game_req && (!disp_req || waited >= WMAX);
      x_dack = disp_req && !x_gack;
      o_dack = disp_ack;
      o_gack = game_ack;
      chk("disp_ack", 32'(disp_ack), 32'(x_dack));
      chk("game_ack", 32'(game_ack), 32'(x_gack));
      chk("ram_en", 32'(ram_en), 32'(e_en[s]));
      if (e_en[s]) begin
         chk("ram_we", 32'(ram_we), 32'(e_we[s]));
         chk("ram_addr", 32'(ram_addr), 32'(e_addr[s]));
         if (e_we[s]) chk("ram_wdata", 32'(ram_wdata), 32'(e_wd[s]));
      end
      if (e_dv[s]) last_dd = e_dd[s];
      if (e_gv[s]) last_gd = e_gd[s];
      chk("disp_valid", 32'(disp_valid), 32'(e_dv[s]));
      chk("disp_data", 32'(disp_data), 32'(last_dd));
      chk("game_valid", 32'(game_valid), 32'(e_gv[s]));
      chk("game_rdata", 32'(game_rdata), 32'(last_gd));
      chk("game_err", 32'(game_err), 32'(e_err[s]));
      clear_slot(s);
      if (rst) begin
         for (int i = 0; i < 64; i++) clear_slot(i);
         waited  = 0;
         last_dd = '0;
         last_gd = '0;
      end else begin
         if (x_dack) begin
            e_en[s1]   = 1'b1;
            e_we[s1]   = 1'b0;
            e_addr[s1] = disp_addr;
            e_dv[s3]   = 1'b1;
            e_dd[s3]   = shadow[disp_addr];
         end
         if (x_gack) begin
            if (oob(game_addr)) begin
               e_err[s3] = 1'b1;
               if (!game_we) begin
                  e_gv[s3] = 1'b1;
                  e_gd[s3] = '0;
               end
            end else begin
               e_en[s1]   = 1'b1;
               e_we[s1]   = game_we;
               e_addr[s1] = game_addr;
               e_wd[s1]   = game_wdata;
               if (game_we) begin
                  shadow[game_addr] = game_wdata;
               end else begin
                  e_gv[s3] = 1'b1;
                  e_gd[s3] = shadow[game_addr];
               end
            end
         end
         waited = (game_req && !x_gack) ? waited + 1 : 0;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      disp_req = 1'b0;
      game_req = 1'b0;
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      bit acked;
      for (int i = 0; i < 512; i++) begin
         ram[i]    = DW'(i % 128);
         shadow[i] = DW'(i % 128);
      end

      // Reset state.
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_ram_en", 32'(ram_en), 32'd0);
      chk("rst_ram_we", 32'(ram_we), 32'd0);
      chk("rst_ram_addr", 32'(ram_addr), 32'd0);
      chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
      chk("rst_disp_valid", 32'(disp_valid), 32'd0);
      chk("rst_disp_data", 32'(disp_data), 32'd0);
      chk("rst_game_valid", 32'(game_valid), 32'd0);
      chk("rst_game_rdata", 32'(game_rdata), 32'd0);
      chk("rst_game_err", 32'(game_err), 32'd0);
      @(posedge clk);
      #1;

      // Display only, addresses wrap 0..299.
      for (int i = 0; i < 310; i++) begin
         disp_req  = 1'b1;
         disp_addr = AW'(i % TC);
         cycle();
      end
      idle(4);

      // Game write then read of the same tile.
      game_req   = 1'b1;
      game_we    = 1'b1;
      game_addr  = AW'(17);
      game_wdata = 7'h2A;
      cycle();
      game_we = 1'b0;
      cycle();
      idle(4);
      chk("wr_rd_17", 32'(game_rdata), 32'h2A);

      // Starvation bound.
      disp_req  = 1'b1;
      disp_addr = AW'(100);
      game_req  = 1'b1;
      game_we   = 1'b0;
      game_addr = AW'(17);
      acked     = 1'b0;
      for (int i = 0; i < 10 && !acked; i++) begin
         cycle();
         if (o_gack) begin
            acked = 1'b1;
            chk("starve_denials", 32'(i), 32'(WMAX));
            chk("starve_disp_ack", 32'(o_dack), 32'd0);
         end
      end
      chk("starve_granted", 32'(acked), 32'd1);
      game_req = 1'b0;
      cycle();
      chk("starve_disp_resume", 32'(o_dack), 32'd1);
      idle(4);

      // Reset mid-operation with a read in flight and a pending game wait.
      disp_req  = 1'b1;
      disp_addr = AW'(42);
      game_req  = 1'b1;
      game_addr = AW'(20);
      cycle();
      cycle();
      disp_req = 1'b0;
      game_req = 1'b0;
      rst      = 1'b1;
      cycle();
      rst = 1'b0;
      cycle();
      chk("mid_rst_ram_we", 32'(ram_we), 32'd0);
      chk("mid_rst_ram_addr", 32'(ram_addr), 32'd0);
      chk("mid_rst_disp_data", 32'(disp_data), 32'd0);
      idle(3);
      // Fresh wait count after reset: game again needs the full bound.
      disp_req = 1'b1;
      game_req = 1'b1;
      for (int i = 0; i < WMAX + 1; i++) cycle();
      idle(4);

      // Out-of-range game accesses.
      game_req  = 1'b1;
      game_we   = 1'b0;
      game_addr = AW'(300);
      cycle();
      game_we    = 1'b1;
      game_addr  = AW'(310);
      game_wdata = 7'h55;
      cycle();
      idle(4);

      // Random traffic.
      disp_req = 1'b0;
      game_req = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (!disp_req || x_dack) begin
            disp_req  = ($urandom_range(0, 99) < 55);
            disp_addr = AW'($urandom_range(0, TC - 1));
         end
         if (!game_req || x_gack) begin
            game_req   = ($urandom_range(0, 99) < 50);
            game_we    = 1'($urandom_range(0, 1));
            game_addr  = ($urandom_range(0, 4) == 0) ?
                         AW'($urandom_range(TC, 511)) :
                         AW'($urandom_range(10, 25));
            game_wdata = DW'($urandom_range(0, 127));
         end
         cycle();
      end
      idle(5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
